// File: rtl/coord_bcd_formatter_pkg.sv
// display_pkg: shared types and constants for the coordinate BCD formatter.
`default_nettype none

package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fmt_state_t;

  localparam int         BCD_DIGITS = 4;
  localparam logic [3:0] BLANK_ZERO = 4'b1110;

  function automatic logic [3:0] add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coord_bcd_formatter_if.sv
// coord_bcd_formatter_if: value inputs, start request and formatted BCD outputs.
`default_nettype none

interface coord_bcd_formatter_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] val_a;
  logic [WIDTH-1:0] val_b;
  logic             start;
  logic [15:0]      bcd_a;
  logic [15:0]      bcd_b;
  logic [7:0]       blank;
  logic             busy;
  logic             done;

  modport master (
    output val_a, val_b, start,
    input  bcd_a, bcd_b, blank, busy, done
  );

  modport slave (
    input  val_a, val_b, start,
    output bcd_a, bcd_b, blank, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/coord_bcd_formatter_dabble_lane.sv
// dabble_lane: one double-dabble lane (binary shifter + 4-digit BCD accumulator)
// with a leading-zero blank mask derived from the accumulator.
`default_nettype none

module dabble_lane
  import display_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [15:0]      acc_o,
  output logic [3:0]       blank_o
);

  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         adj;
  logic [16+WIDTH-1:0] shifted;
  logic                hi_zero;

  generate
    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
      assign adj[4*i +: 4] = add3(acc_q[4*i +: 4]);
    end
  endgenerate

  assign shifted = {adj, bin_q} << 1;

  always_comb begin
    bin_d = bin_q;
    acc_d = acc_q;
    if (load_i) begin
      bin_d = val_i;
      acc_d = '0;
    end else if (step_i) begin
      bin_d = shifted[WIDTH-1:0];
      acc_d = shifted[16+WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      acc_q <= '0;
    end else begin
      bin_q <= bin_d;
      acc_q <= acc_d;
    end
  end

  // Walk down from the top digit; a digit blanks only while everything above is zero.
  always_comb begin
    blank_o = '0;
    hi_zero = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      hi_zero    = hi_zero & (acc_q[4*i +: 4] == 4'd0);
      blank_o[i] = hi_zero;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/coord_bcd_formatter.sv
// coord_bcd_formatter: converts two binary values to packed BCD with leading-zero
// blanking, on request or on a periodic refresh tick; outputs hold between conversions.
`default_nettype none

module coord_bcd_formatter
  import display_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  coord_bcd_formatter_if.slave bus
);

  localparam int CNT_W = 4;

  fmt_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      bcd_a_q, bcd_b_q;
  logic [7:0]       blank_q;
  logic             busy_q, done_q;

  logic        tick;
  logic        go;
  logic        lane_load, lane_step;
  logic [15:0] acc_a, acc_b;
  logic [3:0]  blank_a, blank_b;

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int               REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
      logic [REF_W-1:0] ref_q;

      assign tick = (ref_q == REF_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) ref_q <= '0;
        else       ref_q <= tick ? '0 : ref_q + 1'b1;
      end
    end else begin : g_no_refresh
      assign tick = 1'b0;
    end
  endgenerate

  // go is only acted on in IDLE, so requests during a conversion are simply lost.
  assign go        = bus.start | tick;
  assign lane_load = (state_q == ST_IDLE) && go;
  assign lane_step = (state_q == ST_SHIFT);

  dabble_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (lane_load),
    .step_i  (lane_step),
    .val_i   (bus.val_a),
    .acc_o   (acc_a),
    .blank_o (blank_a)
  );

  dabble_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (lane_load),
    .step_i  (lane_step),
    .val_i   (bus.val_b),
    .acc_o   (acc_b),
    .blank_o (blank_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcd_a_q <= '0;
      bcd_b_q <= '0;
      blank_q <= {BLANK_ZERO, BLANK_ZERO};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Lags the state by one edge so busy covers the cycle after done lands.
      busy_q <= (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) state_q <= ST_DONE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_DONE: begin
          bcd_a_q <= acc_a;
          bcd_b_q <= acc_b;
          blank_q <= {blank_a, blank_b};
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.bcd_a = bcd_a_q;
  assign bus.bcd_b = bcd_b_q;
  assign bus.blank = blank_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_coord_bcd_formatter.sv
// tb_coord_bcd_formatter: randomized self-checking bench against a decimal-digit
// reference model; one instance without refresh, one with a 16-cycle refresh.
`default_nettype none

module tb_coord_bcd_formatter;

  localparam int W = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  coord_bcd_formatter_if #(.WIDTH(W)) if0 ();
  coord_bcd_formatter_if #(.WIDTH(W)) if1 ();

  coord_bcd_formatter #(.WIDTH(W), .REFRESH_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  coord_bcd_formatter #(.WIDTH(W), .REFRESH_CYCLES(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    logic [3:0] m;
    m = 4'b0000;
    if (v < 1000) m[3] = 1'b1;
    if (v < 100)  m[2] = 1'b1;
    if (v < 10)   m[1] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    check({tag, " bcd_a"}, if0.bcd_a, ref_bcd(a));
    check({tag, " bcd_b"}, if0.bcd_b, ref_bcd(b));
    check({tag, " blank"}, if0.blank, {ref_blank(a), ref_blank(b)});
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_conv(input string tag, input int a, input int b);
    int lat;
    lat = -1;
    if0.val_a = 10'(a);
    if0.val_b = 10'(b);
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) check({tag, " busy_rise"}, if0.busy, 1);
      if (if0.done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, lat, W + 1);
    check_result(tag, a, b);
    check({tag, " busy_at_done"}, if0.busy, 1);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, if0.done, 0);
    check({tag, " busy_fall"}, if0.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a, b, lat, pulses, prev, ndone, cur_a, cur_b;
    logic armed;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    if0.val_a = '0; if0.val_b = '0; if0.start = 1'b0;
    if1.val_a = '0; if1.val_b = '0; if1.start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset bcd_a", if0.bcd_a, 16'h0000);
    check("reset bcd_b", if0.bcd_b, 16'h0000);
    check("reset blank", if0.blank, 8'hEE);
    check("reset busy",  if0.busy, 0);
    check("reset done",  if0.done, 0);
    check("reset blank1", if1.blank, 8'hEE);
    reset = 1'b0;
    @(posedge clk); #1;

    run_conv("max_a", 1023, 0);
    check("max_a blank_const", if0.blank, 8'h0E);
    run_conv("mixed", 5, 640);
    check("mixed blank_const", if0.blank, 8'hE8);
    run_conv("zeros", 0, 0);
    run_conv("edge10", 9, 10);
    run_conv("edge1000", 999, 1000);
    run_conv("both_max", 1023, 1023);

    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 1023));
      run_conv("rand", a, b);
    end

    // start held high, val_a disturbed during SHIFT
    if0.val_a = 10'd321;
    if0.val_b = 10'd77;
    if0.start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c >= 1 && c <= 8) if0.val_a = 10'($urandom_range(0, 1023));
      if (if0.done) begin
        lat = c;
        if0.start = 1'b0;
        break;
      end
    end
    check("held latency", lat, W + 1);
    check_result("held", 321, 77);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (if0.done) pulses++;
    end
    check("held extra_done", pulses, 0);

    // reset 5 cycles into SHIFT
    if0.val_a = 10'd456;
    if0.val_b = 10'd12;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst bcd_a", if0.bcd_a, 16'h0000);
    check("midrst bcd_b", if0.bcd_b, 16'h0000);
    check("midrst blank", if0.blank, 8'hEE);
    check("midrst busy",  if0.busy, 0);
    check("midrst done",  if0.done, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (if0.done) pulses++;
    end
    check("midrst no_done", pulses, 0);
    run_conv("after_rst", 456, 12);

    // refresh-driven instance, start tied low
    cur_a = int'($urandom_range(0, 1023));
    cur_b = int'($urandom_range(0, 1023));
    if1.val_a = 10'(cur_a);
    if1.val_b = 10'(cur_b);
    prev  = -1;
    ndone = 0;
    armed = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (if1.done) begin
        if (prev >= 0) check("refresh period", c - prev, 16);
        if (armed) begin
          check("refresh bcd_a", if1.bcd_a, ref_bcd(cur_a));
          check("refresh bcd_b", if1.bcd_b, ref_bcd(cur_b));
          check("refresh blank", if1.blank, {ref_blank(cur_a), ref_blank(cur_b)});
        end
        prev  = c;
        ndone++;
        armed = 1'b1;
        cur_a = int'($urandom_range(0, 1023));
        cur_b = int'($urandom_range(0, 1023));
        if1.val_a = 10'(cur_a);
        if1.val_b = 10'(cur_b);
      end
    end
    check("refresh pulses", (ndone >= 6) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
